fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the fetch stage and decode. It takes a registered fetch bundle of
//  FETCH_WIDTH instructions per cycle and presents up to DECODE_WIDTH in-order instructions, each with its PC.
//  It back-pressures fetch through in_stall, which drives the fetch stall input, and empties on branch/jump redirect.
// PARAMETERS
//  FETCH_WIDTH      `FETCH_WIDTH      instructions per incoming bundle
//  DECODE_WIDTH     2                 max instructions presented/consumed per cycle (<= FETCH_WIDTH)
//  DEPTH            16                entries, power of 2, >= 2*FETCH_WIDTH
//  INST_ADDR_WIDTH  `INST_ADDR_WIDTH  PC width
// PORTS
//  clk        in   1                               clock, rising edge
//  reset      in   1                               asynchronous, active-high reset
//  flush      in   1                               redirect: discard all entries
//  in_valid   in   1                               fetch bundle valid
//  in_inst    in   32 x FETCH_WIDTH                bundle instructions, lane 0 oldest
//  in_pc      in   INST_ADDR_WIDTH                 PC of lane 0
//  in_stall   out  1                               queue cannot accept a full bundle; fetch must hold
//  out_valid  out  DECODE_WIDTH                    lane j valid (thermometer, lane 0 first)
//  out_inst   out  32 x DECODE_WIDTH               instructions, lane 0 oldest
//  out_pc     out  INST_ADDR_WIDTH x DECODE_WIDTH  PC per lane
//  out_ready  in   1                               decode consumes all valid lanes this cycle
//  count      out  $clog2(DEPTH+1)                 current occupancy
// BEHAVIOUR
//  - Reset (async, any cycle): rd_ptr=wr_ptr=0, count=0, storage inst=32'h0000_0013 (NOP), pc=0.
//    Resulting outputs: out_valid=0, in_stall=0, out_inst=NOP, out_pc=0.
//  - in_stall = (DEPTH-count < FETCH_WIDTH). It depends only on registered count. There is no path
//    from out_ready, so the stall is conservative during a same-cycle dequeue.
//  - Enqueue fires when in_valid & ~in_stall & ~flush.
//    Lane i goes to slot (wr_ptr+i) mod DEPTH with pc = in_pc + 4*i; wr_ptr += FETCH_WIDTH.
//    A bundle is enqueued whole or not at all. While in_stall=1 fetch holds the bundle, and it is accepted when in_stall drops.
//  - Output: out_valid[j] = (count > j). out_inst/out_pc[j] = slot (rd_ptr+j) mod DEPTH.
//    These are combinational from registers; there is no added latency.
//  - Dequeue fires when out_ready & ~flush. It removes ndeq = min(count, DECODE_WIDTH); rd_ptr += ndeq.
//    out_ready with count=0 is a no-op.
//  - Simultaneous enqueue and dequeue: count_next = count + (enq?FETCH_WIDTH:0) - ndeq.
//    A bundle written in cycle N is visible at the outputs in cycle N+1 (1-cycle latency when empty).
//  - Flush has priority over enqueue and dequeue. Next cycle: rd_ptr=wr_ptr=0, count=0.
//    Stale storage is not cleared. Lanes shown during the flush cycle are not consumed; decode discards them.
//  - Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Order is preserved across the wrap.
//  - Overflow/underflow cannot occur. count never exceeds DEPTH or goes below 0; the bench asserts this.
// STRUCTURE
//  - The shared core package holds typedef fq_entry_t {logic [31:0] inst; logic [INST_ADDR_WIDTH-1:0] pc;}
//    and localparam NOP_INST = 32'h0000_0013.
//  - Sub-module fetch_queue_ctrl owns rd_ptr/wr_ptr/count, enq/deq/flush arbitration and in_stall.
//    The top level holds the fq_entry_t storage array, the write decode and the read muxes.
// TESTING  (FETCH_WIDTH=4, DECODE_WIDTH=2, DEPTH=8, INST_ADDR_WIDTH=32)
//  1 Reset: assert reset between clock edges mid-stream -> count=0, out_valid=2'b00, in_stall=0 at once, before the next edge.
//  2 Latency/order: one bundle A..D, in_pc=0x100, out_ready=0 -> next cycle count=4, out_valid=11, out_pc={0x104,0x100}.
//    Then out_ready=1 for 2 cycles -> C,D @0x108/0x10C, then count=0.
//  3 Full: two bundles, out_ready=0 -> count=8, in_stall=1; held 3rd bundle not written.
//    out_ready=1 for 2 cycles -> count=4, in_stall=0; held bundle accepted next edge, count=8-2=6.
//  4 Wrap: fill 8, drain 6, enqueue bundle pc=0x200 -> slots 0..3 reused.
//    Drain yields PCs 0x118,0x11C,0x200,0x204,0x208,0x20C in order.
//  5 Flush: count=6, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=00, in_stall=0; nothing enqueued.
//  6 Partial dequeue: count=1, out_ready=1 with simultaneous enqueue -> out_valid=01, count_next=1-1+4=4.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: the storage entry layout and the NOP fill value.
package fetch_queue_pkg;

  localparam int FQ_FETCH_WIDTH     = 4;
  localparam int FQ_INST_ADDR_WIDTH = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // The entry PC width is fixed here; the top-level INST_ADDR_WIDTH must equal FQ_INST_ADDR_WIDTH.
  typedef struct packed {
    logic [31:0]                   inst;
    logic [FQ_INST_ADDR_WIDTH-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Pointer/occupancy control for the fetch queue: enqueue, dequeue and flush arbitration plus the fetch stall.
module fetch_queue_ctrl #(
  parameter  int FETCH_WIDTH  = 4,
  parameter  int DECODE_WIDTH = 2,
  parameter  int DEPTH        = 16,
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             enq_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             in_stall_o
);

  // Handshakes: a bundle moves when in_valid & ~in_stall (stall is registered-only, no path from
  // out_ready); decode takes every valid lane when out_ready is high. Flush overrides both.
  localparam logic [CNT_W-1:0] STALL_THR = CNT_W'(DEPTH - FETCH_WIDTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ndeq;
  logic             deq;

  always_comb begin
    in_stall_o = (count_q > STALL_THR);
    enq_o      = in_valid_i & ~in_stall_o & ~flush_i;
    deq        = out_ready_i & ~flush_i;
    ndeq       = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_o) wr_ptr_d = wr_ptr_q + PTR_W'(FETCH_WIDTH);
      if (deq)   rd_ptr_d = rd_ptr_q + PTR_W'(ndeq);
      count_d = count_q + (enq_o ? CNT_W'(FETCH_WIDTH) : '0) - (deq ? ndeq : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr_o = rd_ptr_q;
  assign wr_ptr_o = wr_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: whole-bundle writes, up to DECODE_WIDTH in-order reads per cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int FETCH_WIDTH     = FQ_FETCH_WIDTH,
  parameter int DECODE_WIDTH    = 2,
  parameter int DEPTH           = 16,
  parameter int INST_ADDR_WIDTH = FQ_INST_ADDR_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic                                          in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]                  in_inst,
  input  logic [INST_ADDR_WIDTH-1:0]                    in_pc,
  output logic                                          in_stall,
  output logic [DECODE_WIDTH-1:0]                       out_valid,
  output logic [DECODE_WIDTH-1:0][31:0]                 out_inst,
  output logic [DECODE_WIDTH-1:0][INST_ADDR_WIDTH-1:0]  out_pc,
  input  logic                                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]                    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enq;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  fetch_queue_ctrl #(
    .FETCH_WIDTH  (FETCH_WIDTH),
    .DECODE_WIDTH (DECODE_WIDTH),
    .DEPTH        (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .out_ready_i (out_ready),
    .enq_o       (enq),
    .rd_ptr_o    (rd_ptr),
    .wr_ptr_o    (wr_ptr),
    .count_o     (count),
    .in_stall_o  (in_stall)
  );

  // Each slot picks the bundle lane whose offset from wr_ptr (modulo DEPTH) lands on it.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      mem_d[s] = mem_q[s];
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (enq && (PTR_W'(s) - wr_ptr == PTR_W'(i))) begin
          mem_d[s].inst = in_inst[i];
          mem_d[s].pc   = in_pc + INST_ADDR_WIDTH'(4 * i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        mem_q[s].inst <= NOP_INST;
        mem_q[s].pc   <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        mem_q[s] <= mem_d[s];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      out_valid[j] = (count > CNT_W'(j));
      out_inst[j]  = mem_q[rd_ptr + PTR_W'(j)].inst;
      out_pc[j]    = mem_q[rd_ptr + PTR_W'(j)].pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed latency/full/wrap/flush/reset cases.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main DUT: FETCH_WIDTH=4, DECODE_WIDTH=2, DEPTH=8
  logic            flush, in_valid, in_stall, out_ready;
  logic [3:0][31:0] in_inst;
  logic [31:0]     in_pc;
  logic [1:0]      out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [3:0]      count;

  // second DUT: FETCH_WIDTH=1 so that odd occupancy (partial dequeue) is reachable
  logic            in_valid1, in_stall1, out_ready1;
  logic [0:0][31:0] in_inst1;
  logic [31:0]     in_pc1;
  logic [1:0]      out_valid1;
  logic [1:0][31:0] out_inst1;
  logic [1:0][31:0] out_pc1;
  logic [2:0]      count1;

  fetch_queue #(.FETCH_WIDTH(4), .DECODE_WIDTH(2), .DEPTH(8), .INST_ADDR_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_stall(in_stall), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_ready(out_ready), .count(count)
  );

  fetch_queue #(.FETCH_WIDTH(1), .DECODE_WIDTH(2), .DEPTH(4), .INST_ADDR_WIDTH(32)) u_dut1 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid1), .in_inst(in_inst1),
    .in_pc(in_pc1), .in_stall(in_stall1), .out_valid(out_valid1), .out_inst(out_inst1),
    .out_pc(out_pc1), .out_ready(out_ready1), .count(count1)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    logic [31:0] base;
    base     = $urandom;
    in_valid = v;
    in_pc    = pc;
    for (int i = 0; i < 4; i++) in_inst[i] = base + 32'(i);
  endtask

  // Compare outputs against the model, apply this cycle's inputs to the model, then advance one edge.
  task automatic cycle();
    int  n;
    int  nd;
    logic stall_m;
    n       = exp_q.size();
    stall_m = ((8 - n) < 4);
    check("count", 64'(count), 64'(n));
    check("in_stall", 64'(in_stall), 64'(stall_m));
    check("out_valid", 64'(out_valid), (n >= 2) ? 64'h3 : (n == 1) ? 64'h1 : 64'h0);
    for (int j = 0; j < 2; j++) begin
      if (j < n) begin
        check("lane_inst", 64'(out_inst[j]), 64'(exp_q[j]));
        check("lane_pc", 64'(out_pc[j]), 64'(exp_pc_q[j]));
      end
    end
    if (flush) begin
      exp_q.delete();
      exp_pc_q.delete();
    end else begin
      if (out_ready) begin
        nd = (n < 2) ? n : 2;
        repeat (nd) begin
          void'(exp_q.pop_front());
          void'(exp_pc_q.pop_front());
        end
      end
      if (in_valid && !stall_m) begin
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(in_inst[i]);
          exp_pc_q.push_back(in_pc + 32'(4 * i));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) check("count_bound", 64'(count <= 4'd8), 64'h1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_inst1 = '0; in_pc1 = '0;
    drive(1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'h0);
    check("rst_out_inst", 64'(out_inst[0]), 64'(NOP));
    check("rst_out_pc", 64'(out_pc[1]), 64'h0);
    reset = 1'b0;
    cycle();

    // single bundle latency and order
    drive(1'b1, 32'h100);
    cycle();
    in_valid = 1'b0;
    check("lat_count", 64'(count), 64'h4);
    check("lat_valid", 64'(out_valid), 64'h3);
    check("lat_pc0", 64'(out_pc[0]), 64'h100);
    check("lat_pc1", 64'(out_pc[1]), 64'h104);
    out_ready = 1'b1;
    cycle();
    check("lat_pc2", 64'(out_pc[0]), 64'h108);
    check("lat_pc3", 64'(out_pc[1]), 64'h10C);
    cycle();
    check("lat_empty", 64'(count), 64'h0);
    out_ready = 1'b0;

    // full: held bundle accepted once stall drops
    drive(1'b1, 32'h300); cycle();
    drive(1'b1, 32'h310); cycle();
    check("full_count", 64'(count), 64'h8);
    check("full_stall", 64'(in_stall), 64'h1);
    drive(1'b1, 32'h320); cycle();
    check("held_count", 64'(count), 64'h8);
    out_ready = 1'b1;
    cycle(); cycle();
    check("unstall_count", 64'(count), 64'h4);
    check("unstall", 64'(in_stall), 64'h0);
    cycle();
    check("accept_count", 64'(count), 64'h6);
    in_valid = 1'b0;
    repeat (3) cycle();

    // pointer wrap with slot reuse
    out_ready = 1'b0;
    drive(1'b1, 32'h100); cycle();
    drive(1'b1, 32'h110); cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check("wrap_head", 64'(out_pc[0]), 64'h118);
    out_ready = 1'b0;
    drive(1'b1, 32'h200); cycle();
    in_valid = 1'b0;
    check("wrap_count", 64'(count), 64'h6);
    out_ready = 1'b1;
    cycle();
    check("wrap_pc0", 64'(out_pc[0]), 64'h200);
    check("wrap_pc1", 64'(out_pc[1]), 64'h204);
    cycle();
    check("wrap_pc2", 64'(out_pc[0]), 64'h208);
    check("wrap_pc3", 64'(out_pc[1]), 64'h20C);
    cycle();

    // flush beats enqueue and dequeue
    out_ready = 1'b0;
    drive(1'b1, 32'h400); cycle();
    drive(1'b1, 32'h410); cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("pre_flush", 64'(count), 64'h6);
    flush = 1'b1;
    drive(1'b1, 32'h420);
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 64'(count), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_stall", 64'(in_stall), 64'h0);
    cycle();

    // simultaneous enqueue and dequeue
    drive(1'b1, 32'h500); cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    drive(1'b1, 32'h510);
    cycle();
    check("enq_deq_count", 64'(count), 64'h4);
    in_valid = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b0;

    // partial dequeue on the FETCH_WIDTH=1 instance
    in_valid1 = 1'b1; in_inst1[0] = 32'hCAFE_0001; in_pc1 = 32'h40; out_ready1 = 1'b1;
    check("p_empty_valid", 64'(out_valid1), 64'h0);
    cycle();
    check("p_count1", 64'(count1), 64'h1);
    check("p_valid1", 64'(out_valid1), 64'h1);
    check("p_pc1", 64'(out_pc1[0]), 64'h40);
    check("p_inst1", 64'(out_inst1[0]), 64'hCAFE_0001);
    in_inst1[0] = 32'hCAFE_0002; in_pc1 = 32'h44;
    cycle();
    check("p_count2", 64'(count1), 64'h1);
    check("p_pc2", 64'(out_pc1[0]), 64'h44);
    check("p_inst2", 64'(out_inst1[0]), 64'hCAFE_0002);
    in_valid1 = 1'b0;
    cycle();
    check("p_drained", 64'(count1), 64'h0);
    out_ready1 = 1'b0;

    // asynchronous reset between edges
    drive(1'b1, 32'h600); cycle();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'h0);
    check("arst_valid", 64'(out_valid), 64'h0);
    check("arst_stall", 64'(in_stall), 64'h0);
    check("arst_inst", 64'(out_inst[1]), 64'(NOP));
    check("arst_pc", 64'(out_pc[0]), 64'h0);
    exp_q.delete();
    exp_pc_q.delete();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
